// File: rtl/one_to_sixteen_deserializer_fsm.sv
// Receive side of the serial link: gathers WIDTH bits while ss is low and
// hands the finished word to the consumer over a valid/ack handshake.
module one_to_sixteen_deserializer_fsm #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             data_input,
  input  logic             ss,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_output,
  output logic             data_valid,
  output logic             overrun,
  output logic             frame_error,
  output logic             busy,
  output logic [1:0]       y_Q
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    DONE = 2'b10,
    BAD  = 2'b11
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]  count;
  logic           ss_q;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic            bit_in);
    if (LSB_FIRST)
      return {bit_in, cur[WIDTH-1:1]};
    else
      return {cur[WIDTH-2:0], bit_in};
  endfunction

  // ss_q follows ss even during reset, so a line held low through reset
  // never looks like a fresh falling edge once reset lifts.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      sh          <= '0;
      count       <= '0;
      data_output <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
      ss_q        <= ss;
    end else begin
      ss_q        <= ss;
      frame_error <= 1'b0;
      if (data_valid && data_ack)
        data_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (ss_q && !ss) begin
            sh    <= shift_in('0, data_input);
            count <= CW'(1);
            state <= RECV;
          end
        end
        RECV: begin
          if (ss) begin
            sh          <= '0;
            count       <= '0;
            frame_error <= 1'b1;
            state       <= IDLE;
          end else begin
            sh    <= shift_in(sh, data_input);
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1))
              state <= DONE;
          end
        end
        // A load here wins over a same-edge ack, keeping data_valid high.
        DONE: begin
          data_output <= sh;
          data_valid  <= 1'b1;
          if (data_valid && !data_ack)
            overrun <= 1'b1;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RECV) || (state == DONE);
  assign y_Q  = state;

endmodule
